player_damage: RTL and testbench

- Receiving end of the monster fireball interface. Consumes the fireball position, size and exist flag, and detects collisions with the player.
- Maintains the player's life count and post-hit invulnerability window. Drives game-over and render-blink signals.
- Sits beside the monster block in the gameplay datapath and is clocked by the frame clock.

---
 rtl/game_pkg.sv | 32 +++
 rtl/box_overlap.sv | 33 +++
 rtl/player_damage.sv | 141 ++++++++++++++
 tb/tb_player_damage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the gameplay blocks (player damage,
// monster, renderer).
//   - game_state_e : encodings of the global game state
//   - coord_t      : 10-bit screen coordinate / half-size
//   - screen bounds and player life defaults
//   - pd_state_e   : player damage sequencer states
package game_pkg;

  typedef enum logic [3:0] {
    GS_START = 4'd0,
    GS_INTRO = 4'd1,
    GS_PLAY  = 4'd2,
    GS_OVER  = 4'd3
  } game_state_e;

  typedef logic [9:0] coord_t;

  localparam int ARENA_LEFT    = 200;
  localparam int SCREEN_HEIGHT = 480;

  localparam int LIFE_INIT_DEF     = 5;
  localparam int LIFE_MAX_DEF      = 9;
  localparam int INVULN_FRAMES_DEF = 30;

  typedef enum logic [1:0] {
    PD_IDLE   = 2'd0,
    PD_ALIVE  = 2'd1,
    PD_INVULN = 2'd2,
    PD_DEAD   = 2'd3
  } pd_state_e;

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational test for two axis-aligned boxes given as
// centre + half-size. Boxes touching exactly on an edge count as overlapping.
// Ports:
//   ax, ay, as : box A centre and half-size
//   bx, by, bs : box B centre and half-size
//   overlap    : 1 when |ax-bx| <= as+bs and |ay-by| <= as+bs
module box_overlap
  import game_pkg::*;
(
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t as,
  input  coord_t bx,
  input  coord_t by,
  input  coord_t bs,
  output logic   overlap
);

  // 11-bit signed differences so a fireball left of / above the player
  // yields a true negative instead of a 10-bit wrap.
  logic signed [10:0] dx_s, dy_s;
  logic [10:0] dx, dy, reach;

  always_comb begin
    dx_s    = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy_s    = $signed({1'b0, ay}) - $signed({1'b0, by});
    dx      = dx_s[10] ? 11'(-dx_s) : 11'(dx_s);
    dy      = dy_s[10] ? 11'(-dy_s) : 11'(dy_s);
    reach   = {1'b0, as} + {1'b0, bs};
    overlap = (dx <= reach) && (dy <= reach);
  end

endmodule

// File: rtl/player_damage.sv
// player_damage: takes fireball hits on the player, tracks life count and
// the post-hit invulnerability window, and drives game-over / blink.
// Ports:
//   frame_clk, Reset            : frame clock, synchronous active-high reset
//   game_state                  : global game state (PLAY_STATE = gameplay)
//   BallX, BallY, BallS         : player centre and half-size
//   fireballX/Y/S, fireball_exist : fireball centre, half-size, in flight
//   heal_pulse                  : adds one life (saturating)
//   player_life, player_hit, player_invuln, player_blink, player_dead :
//                                 registered status outputs
//
// state  | meaning
// IDLE   | not in gameplay; life held at LIFE_INIT
// ALIVE  | vulnerable; an unconsumed overlap costs one life
// INVULN | post-hit window of INVULN_FRAMES frames, hits ignored
// DEAD   | life 0, game over until game_state leaves gameplay or Reset
module player_damage
  import game_pkg::*;
#(
  parameter int          LIFE_INIT     = LIFE_INIT_DEF,
  parameter int          LIFE_MAX      = LIFE_MAX_DEF,
  parameter int          INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter logic [3:0]  PLAY_STATE    = GS_PLAY
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] game_state,
  input  coord_t     BallX,
  input  coord_t     BallY,
  input  coord_t     BallS,
  input  coord_t     fireballX,
  input  coord_t     fireballY,
  input  coord_t     fireballS,
  input  logic       fireball_exist,
  input  logic       heal_pulse,
  output logic [3:0] player_life,
  output logic       player_hit,
  output logic       player_invuln,
  output logic       player_blink,
  output logic       player_dead
);

  localparam logic [3:0] LIFE_INIT_L = 4'(LIFE_INIT);
  localparam logic [3:0] LIFE_MAX_L  = 4'(LIFE_MAX);
  localparam logic [5:0] INV_LOAD    = 6'(INVULN_FRAMES - 1);

  pd_state_e  state_q, state_n;
  logic [3:0] life_n, life_healed;
  logic [5:0] inv_q, inv_n;
  logic       consumed_q, consumed_n;
  logic       hit_n;
  logic       boxes_touch, overlap, hit_ok;

  box_overlap u_box_overlap (
    .ax      (fireballX),
    .ay      (fireballY),
    .as      (fireballS),
    .bx      (BallX),
    .by      (BallY),
    .bs      (BallS),
    .overlap (boxes_touch)
  );

  assign overlap     = fireball_exist & boxes_touch;
  assign hit_ok      = overlap & ~consumed_q;
  assign life_healed = (player_life >= LIFE_MAX_L) ? LIFE_MAX_L : player_life + 4'd1;

  always_comb begin
    state_n    = state_q;
    life_n     = player_life;
    inv_n      = inv_q;
    consumed_n = consumed_q;
    hit_n      = 1'b0;

    // The latch re-arms whenever the fireball leaves flight.
    if (!fireball_exist) consumed_n = 1'b0;

    if (game_state != PLAY_STATE) begin
      state_n    = PD_IDLE;
      life_n     = LIFE_INIT_L;
      inv_n      = '0;
      consumed_n = 1'b0;
    end else begin
      case (state_q)
        PD_IDLE: state_n = PD_ALIVE;
        PD_ALIVE: begin
          if (hit_ok) begin
            hit_n      = 1'b1;
            consumed_n = 1'b1;
            if (heal_pulse) begin
              // heal cancels the damage; the window still starts
              state_n = PD_INVULN;
              inv_n   = INV_LOAD;
            end else if (player_life <= 4'd1) begin
              state_n = PD_DEAD;
              life_n  = 4'd0;
            end else begin
              state_n = PD_INVULN;
              life_n  = player_life - 4'd1;
              inv_n   = INV_LOAD;
            end
          end else if (heal_pulse) begin
            life_n = life_healed;
          end
        end
        PD_INVULN: begin
          // Swallow the overlap so this fireball cannot hit after the window.
          if (overlap) consumed_n = 1'b1;
          if (heal_pulse) life_n = life_healed;
          if (inv_q == 6'd0) state_n = PD_ALIVE;
          else               inv_n   = inv_q - 6'd1;
        end
        PD_DEAD: life_n = 4'd0;
        default: state_n = PD_IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= PD_IDLE;
      player_life   <= LIFE_INIT_L;
      inv_q         <= '0;
      consumed_q    <= 1'b0;
      player_hit    <= 1'b0;
      player_invuln <= 1'b0;
      player_blink  <= 1'b1;
      player_dead   <= 1'b0;
    end else begin
      state_q       <= state_n;
      player_life   <= life_n;
      inv_q         <= inv_n;
      consumed_q    <= consumed_n;
      player_hit    <= hit_n;
      player_invuln <= (state_n == PD_INVULN);
      player_blink  <= (state_n == PD_INVULN) ? ~inv_n[2] : (state_n != PD_DEAD);
      player_dead   <= (state_n == PD_DEAD);
    end
  end

endmodule

// File: tb/tb_player_damage.sv
module tb_player_damage;
  import game_pkg::*;

  logic       frame_clk;
  logic       Reset;
  logic [3:0] game_state;
  coord_t     BallX, BallY, BallS;
  coord_t     fireballX, fireballY, fireballS;
  logic       fireball_exist;
  logic       heal_pulse;
  logic [3:0] player_life;
  logic       player_hit, player_invuln, player_blink, player_dead;

  int checks   = 0;
  int failures = 0;
  int hit_cnt;
  int inv_cnt;

  player_damage dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .game_state     (game_state),
    .BallX          (BallX),
    .BallY          (BallY),
    .BallS          (BallS),
    .fireballX      (fireballX),
    .fireballY      (fireballY),
    .fireballS      (fireballS),
    .fireball_exist (fireball_exist),
    .heal_pulse     (heal_pulse),
    .player_life    (player_life),
    .player_hit     (player_hit),
    .player_invuln  (player_invuln),
    .player_blink   (player_blink),
    .player_dead    (player_dead)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One fireball flight: drop exist for a frame, then overlap (dx = 18).
  task automatic flight(input int exp_life);
    fireball_exist = 1'b0;
    fireballX      = 10'd318;
    step(1);
    fireball_exist = 1'b1;
    step(1);
    chk("flight_hit", int'(player_hit), 1);
    chk("flight_life", int'(player_life), exp_life);
  endtask

  initial begin
    Reset          = 1'b1;
    game_state     = 4'd0;
    BallX          = 10'd250;
    BallY          = 10'd300;
    BallS          = 10'd10;
    fireballX      = 10'd400;
    fireballY      = 10'd300;
    fireballS      = 10'd10;
    fireball_exist = 1'b1;
    heal_pulse     = 1'b0;

    // reset values
    step(2);
    chk("rst_life", int'(player_life), 5);
    chk("rst_hit", int'(player_hit), 0);
    chk("rst_invuln", int'(player_invuln), 0);
    chk("rst_blink", int'(player_blink), 1);
    chk("rst_dead", int'(player_dead), 0);

    // gameplay entry, fireball far away
    Reset      = 1'b0;
    game_state = 4'd2;
    hit_cnt    = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      hit_cnt += int'(player_hit);
    end
    chk("entry_hits", hit_cnt, 0);
    chk("entry_life", int'(player_life), 5);
    chk("entry_invuln", int'(player_invuln), 0);

    // single hit on a lingering fireball, held 50 frames
    BallX     = 10'd300;
    fireballX = 10'd318;
    step(1);
    chk("hit1_pulse", int'(player_hit), 1);
    chk("hit1_life", int'(player_life), 4);
    chk("hit1_invuln", int'(player_invuln), 1);
    chk("hit1_blink_inv29", int'(player_blink), 0);
    hit_cnt = 1;
    inv_cnt = 1;
    for (int i = 1; i < 50; i++) begin
      step(1);
      hit_cnt += int'(player_hit);
      inv_cnt += int'(player_invuln);
    end
    chk("linger_hits", hit_cnt, 1);
    chk("linger_invuln_frames", inv_cnt, 30);
    chk("linger_life", int'(player_life), 4);

    // boundary: dx = 21 misses, dx = 20 hits
    fireball_exist = 1'b0;
    step(1);
    fireballX      = 10'd321;
    fireball_exist = 1'b1;
    step(2);
    chk("dx21_hit", int'(player_hit), 0);
    chk("dx21_life", int'(player_life), 4);
    fireballX = 10'd320;
    step(1);
    chk("dx20_hit", int'(player_hit), 1);
    chk("dx20_life", int'(player_life), 3);
    step(30);
    chk("dx20_window_end", int'(player_invuln), 0);

    // far left fireball: must not alias to a hit
    fireball_exist = 1'b0;
    step(1);
    fireballX      = 10'd5;
    fireball_exist = 1'b1;
    hit_cnt        = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      hit_cnt += int'(player_hit);
    end
    chk("farleft_hits", hit_cnt, 0);
    chk("farleft_life", int'(player_life), 3);

    // left-side overlap (dx = 18 on the negative side) still hits
    fireball_exist = 1'b0;
    step(1);
    fireballX      = 10'd282;
    fireball_exist = 1'b1;
    step(1);
    chk("left_hit", int'(player_hit), 1);
    chk("left_life", int'(player_life), 2);
    step(30);

    // heal saturates at 9
    fireball_exist = 1'b0;
    heal_pulse     = 1'b1;
    step(1);
    chk("heal_first", int'(player_life), 3);
    step(9);
    chk("heal_sat", int'(player_life), 9);
    heal_pulse = 1'b0;

    // leave and re-enter gameplay, then five flights to death
    game_state = 4'd0;
    step(1);
    chk("idle_life", int'(player_life), 5);
    game_state = 4'd2;
    step(1);
    for (int i = 1; i <= 4; i++) begin
      flight(5 - i);
      chk("flight_invuln", int'(player_invuln), 1);
      step(30);
      chk("flight_window_end", int'(player_invuln), 0);
    end
    flight(0);
    chk("death_dead", int'(player_dead), 1);
    chk("death_blink", int'(player_blink), 0);
    chk("death_invuln", int'(player_invuln), 0);

    // dead: further overlap and heal ignored
    fireball_exist = 1'b0;
    step(1);
    fireball_exist = 1'b1;
    heal_pulse     = 1'b1;
    step(2);
    heal_pulse = 1'b0;
    chk("dead_hit", int'(player_hit), 0);
    chk("dead_life", int'(player_life), 0);
    chk("dead_dead", int'(player_dead), 1);

    // exit DEAD through IDLE
    game_state = 4'd0;
    step(1);
    chk("exit_life", int'(player_life), 5);
    chk("exit_dead", int'(player_dead), 0);
    chk("exit_blink", int'(player_blink), 1);
    game_state = 4'd2;
    step(1);

    // down to life 1, then heal on the same edge as a hit
    for (int i = 1; i <= 4; i++) begin
      flight(5 - i);
      step(30);
    end
    fireball_exist = 1'b0;
    step(1);
    fireball_exist = 1'b1;
    heal_pulse     = 1'b1;
    step(1);
    heal_pulse = 1'b0;
    chk("healhit_pulse", int'(player_hit), 1);
    chk("healhit_life", int'(player_life), 1);
    chk("healhit_invuln", int'(player_invuln), 1);
    chk("healhit_dead", int'(player_dead), 0);

    // reset mid-INVULN at inv_cnt = 12
    step(17);
    chk("inv12_invuln", int'(player_invuln), 1);
    chk("inv12_blink", int'(player_blink), 0);
    Reset = 1'b1;
    step(1);
    chk("midrst_life", int'(player_life), 5);
    chk("midrst_invuln", int'(player_invuln), 0);
    chk("midrst_blink", int'(player_blink), 1);
    chk("midrst_hit", int'(player_hit), 0);
    chk("midrst_dead", int'(player_dead), 0);
    Reset = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
